// File: rtl/audio_pkg.sv
// Shared constants for the audio streaming controller: sample width,
// default clock rate and the controller state encodings.
package audio_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int DEFAULT_CLOCK_HZ = 25_000_000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

endpackage

// File: rtl/audio_stream_ctrl_if.sv
// Receiver-side and playback-side stream signals of the audio controller.
// The controller takes the slave view; the SPI receiver / DAC side takes the master view.
interface audio_stream_ctrl_if;
    import audio_pkg::*;

    logic                rx_valid;
    logic [SAMPLE_W-1:0] rx_data;
    logic                rx_active;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;

    modport slave (
        input  rx_valid, rx_data,
        output rx_active, sample_out, sample_valid
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_active, sample_out, sample_valid
    );

endinterface

// File: rtl/sample_fifo.sv
// Sample buffer: first-word-fall-through FIFO with synchronous flush.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // NOTE: every variable assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/audio_stream_ctrl.sv
// Audio playback controller: buffers received samples, waits for a prefill,
// then releases one sample per sample-rate tick; tracks over/underflow.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int CLOCK_HZ   = DEFAULT_CLOCK_HZ,
    parameter int SAMPLE_HZ  = 48_000,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8
) (
    input  logic                          clk_25mhz,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear_status,
    audio_stream_ctrl_if.slave            stream,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow,
    output logic [1:0]                    state_out
);

    localparam int DIV   = CLOCK_HZ / SAMPLE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
    logic                sample_valid_q, sample_valid_d;
    logic                rx_active_q, rx_active_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                push, pop, flush, tick, ovf_set, unf_set;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [LVL_W-1:0]    fifo_lvl, level_post;
    logic                fifo_full, fifo_empty;

    sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
        .clk     (clk_25mhz),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (stream.rx_data),
        .dout    (fifo_dout),
        .level   (fifo_lvl),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tick = (state_q == ST_PLAY) && (tick_cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        flush          = 1'b0;
        unf_set        = 1'b0;
        level_post     = fifo_lvl;
        if (!enable) begin
            state_d      = ST_IDLE;
            tick_cnt_d   = '0;
            sample_out_d = '0;
            flush        = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    flush        = 1'b1;
                    tick_cnt_d   = '0;
                    sample_out_d = '0;
                    state_d      = ST_FILL;
                end
                ST_FILL: begin
                    push       = stream.rx_valid;
                    tick_cnt_d = '0;
                    // Prefill decision uses the level as it will be after this cycle's push.
                    level_post = fifo_lvl + LVL_W'(stream.rx_valid && !fifo_full);
                    if (level_post >= LVL_W'(PREFILL)) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    push       = stream.rx_valid;
                    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
                    if (tick) begin
                        sample_valid_d = 1'b1;
                        if (fifo_empty) begin
                            unf_set      = 1'b1;
                            sample_out_d = '0;
                            state_d      = ST_FILL;
                        end else begin
                            pop          = 1'b1;
                            sample_out_d = fifo_dout;
                        end
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    tick_cnt_d   = '0;
                    sample_out_d = '0;
                    flush        = 1'b1;
                end
            endcase
        end
        ovf_set     = push && fifo_full && !pop;
        overflow_d  = ovf_set || (overflow_q && !clear_status);
        underflow_d = unf_set || (underflow_q && !clear_status);
        rx_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            rx_active_q    <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            rx_active_q    <= rx_active_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign stream.rx_active    = rx_active_q;
    assign stream.sample_out   = sample_out_q;
    assign stream.sample_valid = sample_valid_q;
    assign fifo_level          = fifo_lvl;
    assign overflow            = overflow_q;
    assign underflow           = underflow_q;
    assign state_out           = state_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Self-checking bench for audio_stream_ctrl: played samples are checked
// against a queue of expected values filled as stimulus is driven.
module tb_audio_stream_ctrl;
    import audio_pkg::*;

    localparam int CLOCK_HZ   = 25_000_000;
    localparam int SAMPLE_HZ  = 48_000;
    localparam int DIV        = CLOCK_HZ / SAMPLE_HZ;
    localparam int FIFO_DEPTH = 16;
    localparam int PREFILL    = 8;

    logic       clk_25mhz = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       clear_status;
    logic [4:0] fifo_level;
    logic       overflow, underflow;
    logic [1:0] state_out;

    audio_stream_ctrl_if sif ();

    audio_stream_ctrl #(
        .CLOCK_HZ   (CLOCK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PREFILL    (PREFILL)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear_status (clear_status),
        .stream       (sif),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underflow    (underflow),
        .state_out    (state_out)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #1;
        end
    endtask

    task automatic push_word(input logic [15:0] d, input bit expect_kept);
        sif.rx_valid = 1'b1;
        sif.rx_data  = d;
        if (expect_kept) exp_q.push_back(d);
        step(1);
        sif.rx_valid = 1'b0;
    endtask

    // Scoreboard side: every sample_valid pulse consumes one expected value.
    always @(negedge clk_25mhz) begin
        if (reset_n && sif.sample_valid) begin
            if (exp_q.size() == 0) check("sample_unexpected", 32'(sif.sample_out), 32'hFFFF_FFFF);
            else check("sample_out", 32'(sif.sample_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int cnt;
        reset_n      = 1'b0;
        enable       = 1'b0;
        clear_status = 1'b0;
        sif.rx_valid = 1'b0;
        sif.rx_data  = '0;
        step(3);
        reset_n = 1'b1;
        step(1);

        check("rst_state", 32'(state_out), 32'(ST_IDLE));
        check("rst_level", 32'(fifo_level), 0);
        check("rst_rx_active", 32'(sif.rx_active), 0);
        check("rst_sample_out", 32'(sif.sample_out), 0);
        check("rst_flags", {30'd0, overflow, underflow}, 0);

        // rx_valid while idle must be ignored
        push_word(16'hDEAD, 1'b0);
        check("idle_push_level", 32'(fifo_level), 0);
        check("idle_push_ovf", 32'(overflow), 0);

        // Prefill then first sample latency
        enable = 1'b1;
        step(1);
        check("fill_state", 32'(state_out), 32'(ST_FILL));
        check("fill_rx_active", 32'(sif.rx_active), 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) check("fill_before_8th", 32'(state_out), 32'(ST_FILL));
            push_word(16'(i), 1'b1);
        end
        check("play_state", 32'(state_out), 32'(ST_PLAY));
        check("play_level", 32'(fifo_level), 8);
        cnt = 0;
        while (!sif.sample_valid && cnt < 3 * DIV) begin
            step(1);
            cnt++;
        end
        check("first_valid_latency", 32'(cnt), 32'(DIV));
        check("first_sample", 32'(sif.sample_out), 32'h0001);
        step(1);
        check("valid_one_cycle", 32'(sif.sample_valid), 0);
        check("sample_held", 32'(sif.sample_out), 32'h0001);

        // Drain to underflow
        exp_q.push_back(16'h0000);
        cnt = 0;
        while (state_out != ST_FILL && cnt < 10 * DIV) begin
            step(1);
            cnt++;
        end
        check("underflow_state", 32'(state_out), 32'(ST_FILL));
        check("underflow_flag", 32'(underflow), 1);
        check("underflow_sample", 32'(sif.sample_out), 0);
        step(1);
        check("drain_scoreboard", 32'(exp_q.size()), 0);

        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        check("clear_underflow", 32'(underflow), 0);

        // Overflow: 17 back-to-back pushes, 8th one enters PLAY at edge E
        for (int i = 0; i < 17; i++) push_word(16'h0100 + 16'(i), i < 16);
        check("ovf_level", 32'(fifo_level), 16);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_state", 32'(state_out), 32'(ST_PLAY));
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        check("clear_overflow", 32'(overflow), 0);

        // Now just after edge E+10; drive a push into the tick cycle (E+DIV-1 .. E+DIV)
        step(DIV - 11);
        check("pre_tick_no_valid", 32'(sif.sample_valid), 0);
        push_word(16'h0200, 1'b1);
        check("full_pushpop_level", 32'(fifo_level), 16);
        check("full_pushpop_ovf", 32'(overflow), 0);
        check("full_pushpop_valid", 32'(sif.sample_valid), 1);
        check("full_pushpop_head", 32'(sif.sample_out), 32'h0100);

        // Disable while playing with five buffered samples
        cnt = 0;
        while (fifo_level != 5'd5 && cnt < 20 * DIV) begin
            step(1);
            cnt++;
        end
        check("level_reached_5", 32'(fifo_level), 5);
        enable = 1'b0;
        step(1);
        check("dis_scoreboard", 32'(exp_q.size()), 5);
        exp_q.delete();
        check("dis_state", 32'(state_out), 32'(ST_IDLE));
        check("dis_rx_active", 32'(sif.rx_active), 0);
        check("dis_level", 32'(fifo_level), 0);
        check("dis_sample_out", 32'(sif.sample_out), 0);

        // Asynchronous reset mid-PLAY
        enable = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++) push_word(16'h0300 + 16'(i), 1'b1);
        step(DIV + 3);
        check("pre_reset_sample", 32'(sif.sample_out), 32'h0300);
        #7;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_state", 32'(state_out), 32'(ST_IDLE));
        check("arst_rx_active", 32'(sif.rx_active), 0);
        check("arst_sample_out", 32'(sif.sample_out), 0);
        check("arst_valid", 32'(sif.sample_valid), 0);
        check("arst_level", 32'(fifo_level), 0);
        check("arst_flags", {30'd0, overflow, underflow}, 0);
        step(1);
        reset_n = 1'b1;
        step(1);
        check("reenable_state", 32'(state_out), 32'(ST_FILL));
        check("reenable_rx_active", 32'(sif.rx_active), 1);
        check("final_scoreboard", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
